synth_wave_top: RTL and testbench

Top-level digital oscillator for the synth. A free-running phase accumulator drives one of four selectable 8-bit waveform shapers: sawtooth, square, triangle or pseudo-random noise. The selected sample is registered and presented on Waveform, which feeds the DAC/output stage.

---
 rtl/synth_wave_if.sv | 23 ++
 rtl/synth_wave_top.sv | 113 +++++++++++
 tb/tb_synth_wave_top.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/synth_wave_if.sv
// -----------------------------------------------------------------------------
// synth_wave_if
//   Bundles the oscillator's waveform select and sample output.
//
//   Signals:
//     WaveType [1:0] : waveform select, 00 saw, 01 square, 10 triangle, 11 noise
//     Waveform [7:0] : registered unsigned sample, 0x00 minimum, 0xFF full scale
//
//   Handshake: none. WaveType carries no valid/ready pair. It is a level that
//   the oscillator samples on every rising clock edge. Waveform is a
//   free-running registered stream that changes on every edge once out of reset.
//
//   Modports:
//     master : drives WaveType, observes Waveform (controller / testbench side)
//     slave  : observes WaveType, drives Waveform (oscillator side)
// -----------------------------------------------------------------------------
interface synth_wave_if;
   logic [1:0] WaveType;
   logic [7:0] Waveform;

   modport master (output WaveType, input Waveform);
   modport slave  (input WaveType, output Waveform);
endinterface

// File: rtl/synth_wave_top.sv
// -----------------------------------------------------------------------------
// synth_wave_top
//   Digital oscillator. A free-running phase accumulator feeds one of four
//   8-bit waveform shapers: sawtooth, square, triangle or LFSR noise. The
//   selected sample is registered and driven onto Waveform.
//
//   Parameters:
//     ACC_WIDTH : phase accumulator width (>= 9); the top 8 bits form the phase index
//     FREQ_WORD : phase increment per clock
//     LFSR_SEED : reset value of the noise LFSR; 0 is replaced by 16'h0001
//
//   Ports:
//     Clock : system clock, rising-edge active
//     Reset : asynchronous active-low reset
//     wave  : synth_wave_if slave (WaveType in, Waveform out)
// -----------------------------------------------------------------------------
module synth_wave_top #(
   parameter int                   ACC_WIDTH = 16,
   parameter logic [ACC_WIDTH-1:0] FREQ_WORD = 16'h0200,
   parameter logic [15:0]          LFSR_SEED = 16'hACE1
) (
   input  logic         Clock,
   input  logic         Reset,
   synth_wave_if.slave  wave
);

   localparam logic [1:0] WAVE_SAW  = 2'b00;
   localparam logic [1:0] WAVE_SQR  = 2'b01;
   localparam logic [1:0] WAVE_TRI  = 2'b10;
   localparam logic [1:0] WAVE_NOIS = 2'b11;

   // An all-zero LFSR would lock up, so a zero seed is replaced.
   localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   // --------------------------------------------------------------------------
   // Reset release synchroniser
   //   Reset asserts asynchronously everywhere. On release, rst_sync_q captures
   //   the deasserted level on the first edge. The state registers then sample
   //   it as a synchronous enable, which makes them the second stage. State
   //   therefore first advances on the second rising edge after Reset rises.
   // --------------------------------------------------------------------------
   logic rst_sync_q, rst_sync_d;

   // --------------------------------------------------------------------------
   // Datapath state
   // --------------------------------------------------------------------------
   logic [ACC_WIDTH-1:0] phase_q, phase_d;
   logic [15:0]          lfsr_q,  lfsr_d;
   logic [7:0]           wave_q,  wave_d;

   logic [7:0] phase_idx;
   logic [7:0] tri_up;
   logic [7:0] shape_c;
   logic       lfsr_fb;

   // The phase index is the pre-increment value. The output register adds
   // exactly one clock of latency, so the first sample after reset is P=0.
   assign phase_idx = phase_q[ACC_WIDTH-1 -: 8];

   // Triangle rises at twice the phase rate in the first half of the cycle.
   // It mirrors by bit inversion in the second half, so the peak is 0xFF
   // and the next sample steps down from there.
   assign tri_up = {phase_idx[6:0], 1'b0};

   // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1.
   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   // Waveform shaper
   always_comb begin
      shape_c = 8'h00;
      case (wave.WaveType)
         WAVE_SAW:  shape_c = phase_idx;
         WAVE_SQR:  shape_c = phase_idx[7] ? 8'hFF : 8'h00;
         WAVE_TRI:  shape_c = phase_idx[7] ? ~tri_up : tri_up;
         WAVE_NOIS: shape_c = lfsr_q[7:0];
         default:   shape_c = 8'h00;
      endcase
   end

   // Next-state logic
   always_comb begin
      rst_sync_d = 1'b1;
      phase_d    = phase_q;
      lfsr_d     = lfsr_q;
      wave_d     = wave_q;
      if (rst_sync_q) begin
         // Accumulator wraps modulo 2^ACC_WIDTH.
         phase_d = phase_q + FREQ_WORD;
         // The LFSR runs regardless of WaveType, so noise depends only on
         // clocks since reset.
         lfsr_d  = {lfsr_q[14:0], lfsr_fb};
         wave_d  = shape_c;
      end
   end

   // State registers
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         rst_sync_q <= 1'b0;
         phase_q    <= '0;
         lfsr_q     <= SEED_EFF;
         wave_q     <= 8'h00;
      end else begin
         rst_sync_q <= rst_sync_d;
         phase_q    <= phase_d;
         lfsr_q     <= lfsr_d;
         wave_q     <= wave_d;
      end
   end

   assign wave.Waveform = wave_q;

endmodule

// File: tb/tb_synth_wave_top.sv
// -----------------------------------------------------------------------------
// tb_synth_wave_top
//   Directed bench for synth_wave_top with the default parameters. Samples are
//   checked one time unit after each rising edge against hand-computed
//   constants and against a small reference model. The model keeps its own
//   phase index and LFSR.
// -----------------------------------------------------------------------------
module tb_synth_wave_top;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   // reference model state
   logic [7:0]  m_phase;
   logic [15:0] m_lfsr;

   synth_wave_if wif ();

   synth_wave_top dut (
      .Clock (clk),
      .Reset (rst_n),
      .wave  (wif)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] model_shape(input logic [1:0] wt, input logic [7:0] p,
                                              input logic [15:0] s);
      logic [7:0] r;
      case (wt)
         2'b00:   r = p;
         2'b01:   r = (p >= 8'd128) ? 8'd255 : 8'd0;
         2'b10:   r = (p < 8'd128) ? 8'(p * 2) : 8'(8'd255 - 8'((p - 8'd128) * 2));
         default: r = s[7:0];
      endcase
      return r;
   endfunction

   task automatic model_reset();
      m_phase = 8'h00;
      m_lfsr  = 16'hACE1;
   endtask

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One advancing edge: compare the DUT sample to the model, then advance the model.
   task automatic adv_check(input string tag, output logic [7:0] obs);
      logic [7:0] e;
      e = model_shape(wif.WaveType, m_phase, m_lfsr);
      step();
      obs = wif.Waveform;
      check(tag, obs, e);
      m_phase = m_phase + 8'h02;
      m_lfsr  = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
   endtask

   // Assert reset mid-cycle, confirm the async clear, hold, then release. After
   // return, one edge has passed since release without any advance.
   task automatic do_reset(input string tag);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check({tag, "_async_clr"}, wif.Waveform, 8'h00);
      step();
      check({tag, "_hold"}, wif.Waveform, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step();
      check({tag, "_rel_edge1"}, wif.Waveform, 8'h00);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] s;
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      wif.WaveType = 2'b00;
      model_reset();

      // Reset hold with WaveType toggling.
      for (int i = 0; i < 5; i++) begin
         wif.WaveType = 2'(i);
         step();
         check("reset_hold", wif.Waveform, 8'h00);
      end

      // Sawtooth from reset.
      wif.WaveType = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("saw_rel_edge1", wif.Waveform, 8'h00);
      for (int i = 0; i < 130; i++) begin
         adv_check("saw", s);
         if (i == 0)   check("saw_s0",   s, 8'h00);
         if (i == 1)   check("saw_s1",   s, 8'h02);
         if (i == 127) check("saw_s127", s, 8'hFE);
         if (i == 128) check("saw_wrap", s, 8'h00);
      end

      // Square from reset.
      wif.WaveType = 2'b01;
      do_reset("sqr");
      for (int i = 0; i < 130; i++) begin
         adv_check("sqr", s);
         if (i == 0)   check("sqr_s0",   s, 8'h00);
         if (i == 63)  check("sqr_s63",  s, 8'h00);
         if (i == 64)  check("sqr_s64",  s, 8'hFF);
         if (i == 127) check("sqr_s127", s, 8'hFF);
         if (i == 128) check("sqr_wrap", s, 8'h00);
      end

      // Triangle from reset.
      wif.WaveType = 2'b10;
      do_reset("tri");
      for (int i = 0; i < 130; i++) begin
         adv_check("tri", s);
         if (i == 0)   check("tri_s0",   s, 8'h00);
         if (i == 1)   check("tri_s1",   s, 8'h04);
         if (i == 63)  check("tri_s63",  s, 8'hFC);
         if (i == 64)  check("tri_peak", s, 8'hFF);
         if (i == 65)  check("tri_s65",  s, 8'hFB);
         if (i == 127) check("tri_s127", s, 8'h03);
         if (i == 128) check("tri_wrap", s, 8'h00);
      end

      // Noise from reset, over more than one full LFSR period.
      wif.WaveType = 2'b11;
      do_reset("noise");
      for (int i = 0; i < 66000; i++) begin
         adv_check("noise", s);
         if (i == 0) check("noise_s0", s, 8'hE1);
         if (i == 1) check("noise_s1", s, 8'hC3);
         if (i == 2) check("noise_s2", s, 8'h87);
      end

      // Mid-run switching with a continuous phase, then reset mid-cycle.
      wif.WaveType = 2'b00;
      do_reset("sw");
      for (int i = 0; i < 125; i++) adv_check("sw_saw", s);
      check("sw_saw_last", s, 8'hF8);
      wif.WaveType = 2'b01;
      adv_check("sw_sqr", s);
      check("sw_sqr_first", s, 8'hFF);
      for (int i = 1; i < 125; i++) adv_check("sw_sqr", s);
      wif.WaveType = 2'b10;
      adv_check("sw_tri", s);
      // sample 250 -> P = 500 mod 256 = 0xF4, falling side: ~0xE8 = 0x17
      check("sw_tri_first", s, 8'h17);
      for (int i = 1; i < 40; i++) adv_check("sw_tri", s);
      do_reset("sw_rst");
      adv_check("sw_restart", s);
      check("sw_restart_s0", s, 8'h00);
      adv_check("sw_restart", s);
      check("sw_restart_s1", s, 8'h04);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
